adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_ctrl.sv | 76 +++++++
 tb/tb_adder_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WIDTH-bit adder that reuses one 2-bit slice, two bits per clock
module adder2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b0, cin};
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout
);
  localparam int N = WIDTH / 2;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       w_s;
  logic             w_co, w_cap, w_last;
  logic [WIDTH+1:0] w_ext;
  adder2 u_slice (.a(r_a[1:0]), .b(r_b[1:0]), .cin(r_c), .s(w_s), .cout(w_co));
  assign w_cap  = start && r_state != RUN;
  assign w_last = r_state == RUN && r_cnt == CW'(N - 1);
  assign w_ext  = {w_s, r_sr};
  assign busy   = r_state == RUN;
  assign done   = r_state == DONE;
  // state register
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // next state: capture wins from IDLE/DONE, RUN ends after the last slice step
  always_comb begin
    w_next = w_cap ? RUN : w_last ? DONE : r_state == DONE ? IDLE : r_state;
  end
  // operand capture, slice stepping and result publish on the final step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_sr  <= '0;
      r_cnt <= '0;
      SUM   <= '0;
      Cout  <= 1'b0;
    end else if (w_cap) begin
      r_a   <= A;
      r_b   <= B;
      r_c   <= Cin;
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (busy) begin
      r_a   <= r_a >> 2;
      r_b   <= r_b >> 2;
      r_c   <= w_co;
      r_sr  <= w_ext[WIDTH+1:2];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        SUM  <= w_ext[WIDTH+1:2];
        Cout <= w_co;
      end
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed vectors at WIDTH=8 plus randomized ops at WIDTH=2/8/16
module tb_adder_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic rr = 1'b1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic       drst, dst, dci, dbz, ddn, dco;
  logic [7:0] da, db, ds;
  logic [7:0] ps;
  logic       pco;
  adder_seq_ctrl #(.WIDTH(8)) d (
    .clk(clk), .reset(drst), .start(dst), .A(da), .B(db), .Cin(dci),
    .busy(dbz), .done(ddn), .SUM(ds), .Cout(dco)
  );
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t vec[8];
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [7:0] es, input logic eco);
    dst = 1'b1; da = a; db = b; dci = ci;
    @(negedge clk);
    dst = 1'b0; da = ~a; db = 8'($urandom); dci = ~ci;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("busy c%0d", k), {dbz, ddn}, 2'b10);
      chk($sformatf("hold c%0d", k), {dco, ds}, {pco, ps});
      @(negedge clk);
    end
    chk("done c5", {dbz, ddn}, 2'b01);
    chk($sformatf("sum %h+%h+%h", a, b, ci), {dco, ds}, {eco, es});
    ps = es; pco = eco;
  endtask
  for (genvar g = 0; g < 3; g++) begin : rnd
    localparam int W = g == 0 ? 2 : g == 1 ? 8 : 16;
    localparam int N = W / 2;
    logic         st, ci, bz, dn, co;
    logic [W-1:0] a, b, s;
    logic [W:0]   lv, e;
    logic [W:0]   q[$];
    int           due[$];
    int           cyc, ops;
    bit           fin;
    adder_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(rr), .start(st), .A(a), .B(b), .Cin(ci),
      .busy(bz), .done(dn), .SUM(s), .Cout(co)
    );
    initial begin
      st = 1'b0; a = '0; b = '0; ci = 1'b0; lv = '0; cyc = 0; ops = 0; fin = 1'b0;
      @(negedge clk);
      while (rr) @(negedge clk);
      while (ops < 1000 && cyc < 30000) begin
        if (dn) begin
          if (q.size() == 0) chk($sformatf("w%0d spurious done", W), dn, 1'b0);
          else begin
            chk($sformatf("w%0d latency", W), cyc, due[0]);
            chk($sformatf("w%0d sum", W), {co, s}, q[0]);
            lv = q[0];
            void'(q.pop_front());
            void'(due.pop_front());
            ops++;
          end
        end else begin
          chk($sformatf("w%0d hold", W), {co, s}, lv);
          if (due.size() != 0 && due[0] <= cyc) begin
            chk($sformatf("w%0d missing done", W), dn, 1'b1);
            void'(q.pop_front());
            void'(due.pop_front());
            ops++;
          end
        end
        st = $urandom_range(0, 3) == 0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        if (st && !bz) begin
          e = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
          q.push_back(e);
          due.push_back(cyc + N + 1);
        end
        @(negedge clk);
        cyc++;
      end
      st = 1'b0;
      fin = 1'b1;
    end
  end
  initial begin
    int nd;
    vec[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vec[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
    vec[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vec[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vec[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vec[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vec[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    drst = 1'b1; dst = 1'b0; da = '0; db = '0; dci = 1'b0; ps = '0; pco = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset state", {dbz, ddn, dco, ds}, 11'h0);
    drst = 1'b0; rr = 1'b0;
    foreach (vec[i]) op(vec[i].a, vec[i].b, vec[i].ci, vec[i].s, vec[i].co);
    @(negedge clk);
    chk("single done pulse", {dbz, ddn}, 2'b00);
    chk("hold after done", {dco, ds}, {pco, ps});
    dst = 1'b1; da = 8'h5A; db = 8'h3C; dci = 1'b1;
    @(negedge clk);
    dst = 1'b0;
    @(negedge clk);
    dst = 1'b1; da = 8'h11; db = 8'h11; dci = 1'b0;
    @(negedge clk);
    dst = 1'b0;
    nd = 0;
    for (int c = 3; c <= 12; c++) begin
      if (ddn) begin
        nd++;
        chk("ignored start done cycle", c, 5);
        chk("ignored start sum", {dco, ds}, 9'h097);
      end
      @(negedge clk);
    end
    chk("ignored start done count", nd, 1);
    dst = 1'b1; da = 8'hFF; db = 8'hFF; dci = 1'b1;
    @(negedge clk);
    dst = 1'b0;
    repeat (2) @(negedge clk);
    drst = 1'b1;
    @(negedge clk);
    drst = 1'b0;
    chk("mid-run reset", {dbz, ddn, dco, ds}, 11'h0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (ddn) nd++;
      @(negedge clk);
    end
    chk("no done after abort", nd, 0);
    ps = '0; pco = 1'b0;
    op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    @(negedge clk);
    drst = 1'b1; dst = 1'b1; da = 8'h01; db = 8'h02; dci = 1'b0;
    @(negedge clk);
    drst = 1'b0; dst = 1'b0;
    chk("reset beats start", {dbz, ddn, dco, ds}, 11'h0);
    @(negedge clk);
    chk("still idle after reset+start", {dbz, ddn}, 2'b00);
    ps = '0; pco = 1'b0;
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    for (int t = 0; t < 60000 && !(rnd[0].fin && rnd[1].fin && rnd[2].fin); t++) @(negedge clk);
    if (!(rnd[0].fin && rnd[1].fin && rnd[2].fin)) begin
      checks++;
      errors++;
      $display("FAIL random timeout: fin=%b%b%b required 111", rnd[2].fin, rnd[1].fin, rnd[0].fin);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
